hssl_cfg_pkt_splitter: RTL



---
 rtl/hssl_cfg_pkt_splitter_pkg.sv | 28 ++
 rtl/hssl_pkt_fifo2.sv | 62 ++++++
 rtl/hssl_cfg_pkt_splitter.sv | 76 +++++++
 3 files changed

// File: rtl/hssl_cfg_pkt_splitter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hssl_cfg_pkt_splitter_pkg: packet field layout and register-bank defaults  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package hssl_cfg_pkt_splitter_pkg;

  localparam int PKT_W        = 72;
  localparam int PKT_PLD_LSB  = 40;
  localparam int PKT_KEY_LSB  = 8;
  localparam int PKT_PLF_BIT  = 1;
  localparam int PRX_ADR_BITS = 8;

  localparam logic [31:0] DEF_CFG_KEY  = 32'hffff_fe00;
  localparam logic [31:0] DEF_CFG_MASK = 32'hffff_ff00;

  typedef logic [1:0] fifo_cnt_t;

  function automatic logic [31:0] pkt_key(input logic [PKT_W-1:0] p);
    return p[PKT_KEY_LSB +: 32];
  endfunction

  function automatic logic [31:0] pkt_pld(input logic [PKT_W-1:0] p);
    return p[PKT_PLD_LSB +: 32];
  endfunction

endpackage
`default_nettype wire

// File: rtl/hssl_pkt_fifo2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hssl_pkt_fifo2: 2-entry registered valid/ready FIFO, head output registered |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module hssl_pkt_fifo2
  import hssl_cfg_pkt_splitter_pkg::*;
#(
  parameter int WIDTH = 72
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy
);

  logic             r_live;
  fifo_cnt_t        r_count;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             w_push;
  logic             w_pop;

  assign w_push = in_vld && in_rdy;
  assign w_pop  = out_vld && out_rdy;

  // r_live keeps ready low while reset is held and for the release edge
  assign in_rdy   = r_live && (r_count != 2'd2);
  assign out_vld  = (r_count != 2'd0);
  assign out_data = r_head;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_live  <= 1'b0;
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_live <= 1'b1;
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= in_data;
          else                 r_tail <= in_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        // Simultaneous push/pop only happens at count 1: new entry replaces head
        2'b11:   r_head <= in_data;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/hssl_cfg_pkt_splitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hssl_cfg_pkt_splitter: config packets -> register writes, others pass on   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module hssl_cfg_pkt_splitter
  import hssl_cfg_pkt_splitter_pkg::*;
#(
  parameter logic [31:0] CFG_KEY  = DEF_CFG_KEY,
  parameter logic [31:0] CFG_MASK = DEF_CFG_MASK,
  parameter int          ADR_BITS = PRX_ADR_BITS
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [PKT_W-1:0]    pkt_data_in,
  input  logic                pkt_vld_in,
  output logic                pkt_rdy_out,
  output logic [PKT_W-1:0]    pkt_data_out,
  output logic                pkt_vld_out,
  input  logic                pkt_rdy_in,
  output logic [ADR_BITS-1:0] prx_addr_out,
  output logic [31:0]         prx_wdata_out,
  output logic                prx_en_out,
  output logic                cfg_cnt_out,
  output logic                cfg_drop_out,
  output logic                pass_cnt_out
);

  logic          w_accept;
  logic          w_is_cfg;
  logic          w_has_pld;
  logic [31:0]   w_key;
  logic          w_fifo_vld;

  assign w_key      = pkt_key(pkt_data_in);
  assign w_is_cfg   = ((w_key & CFG_MASK) == CFG_KEY);
  assign w_has_pld  = pkt_data_in[PKT_PLF_BIT];
  assign w_accept   = pkt_vld_in && pkt_rdy_out;
  assign w_fifo_vld = pkt_vld_in && !w_is_cfg;

  // Config packets share the FIFO's ready so back-pressure stalls them too
  hssl_pkt_fifo2 #(
    .WIDTH (PKT_W)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .in_data  (pkt_data_in),
    .in_vld   (w_fifo_vld),
    .in_rdy   (pkt_rdy_out),
    .out_data (pkt_data_out),
    .out_vld  (pkt_vld_out),
    .out_rdy  (pkt_rdy_in)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prx_en_out    <= 1'b0;
      prx_addr_out  <= '0;
      prx_wdata_out <= '0;
      cfg_cnt_out   <= 1'b0;
      cfg_drop_out  <= 1'b0;
      pass_cnt_out  <= 1'b0;
    end else begin
      prx_en_out   <= w_accept && w_is_cfg && w_has_pld;
      cfg_cnt_out  <= w_accept && w_is_cfg && w_has_pld;
      cfg_drop_out <= w_accept && w_is_cfg && !w_has_pld;
      pass_cnt_out <= w_accept && !w_is_cfg;
      if (w_accept && w_is_cfg && w_has_pld) begin
        prx_addr_out  <= w_key[ADR_BITS-1:0];
        prx_wdata_out <= pkt_pld(pkt_data_in);
      end
    end
  end

endmodule
`default_nettype wire
